// File: rtl/kgp_risc_pkg.sv
// Shared types and defaults for the KGP_RISC fetch front end.
package kgp_risc_pkg;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2,
        HALT  = 2'd3
    } seq_state_t;

    localparam int unsigned DEF_INSTR_BYTES = 4;
    localparam int unsigned DEF_RESET_PC    = 0;

endpackage

// File: rtl/pc_ras.sv
// pc_ras: circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] pop_data,
    output logic              empty,
    output logic              full
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [ADDR_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  top_q, top_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [PTR_W-1:0]  top_inc, top_dec;

    // top_q is the next free slot; the newest entry sits one below it.
    always_comb begin
        top_inc = (top_q == PTR_W'(DEPTH - 1)) ? '0 : top_q + 1'b1;
        top_dec = (top_q == '0) ? PTR_W'(DEPTH - 1) : top_q - 1'b1;
        top_d   = top_q;
        cnt_d   = cnt_q;
        if (push && !pop) begin
            top_d = top_inc;
            if (cnt_q != CNT_W'(DEPTH)) begin
                cnt_d = cnt_q + 1'b1;
            end
        end else if (pop && !push && (cnt_q != '0)) begin
            top_d = top_dec;
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            top_q <= '0;
            cnt_q <= '0;
        end else begin
            top_q <= top_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !pop) begin
            mem_q[top_q] <= push_data;
        end
    end

    assign pop_data = mem_q[top_dec];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CNT_W'(DEPTH));

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer: next-PC controller (fetch, redirects, stall, halt) for KGP_RISC.
// Define PC_SEQ_RAS_EN to add the call/return address stack (pc_ras).
module pc_sequencer
    import kgp_risc_pkg::*;
#(
    parameter int unsigned       ADDR_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = ADDR_W'(DEF_RESET_PC),
    parameter int unsigned       INSTR_BYTES = DEF_INSTR_BYTES,
    parameter int unsigned       RAS_DEPTH   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              br_valid,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_target,
    input  logic              jmp_valid,
    input  logic [ADDR_W-1:0] jmp_target,
    input  logic              call_valid,
    input  logic              ret_valid,
    input  logic              halt,
    input  logic              resume,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pc_valid,
    output logic              flush,
    output logic              misalign,
    output logic              ras_empty
);

    localparam logic [ADDR_W-1:0] INC_VAL     = ADDR_W'(INSTR_BYTES);
    localparam logic [ADDR_W-1:0] OFFSET_MASK = ADDR_W'(INSTR_BYTES - 1);

    seq_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              flush_q, flush_d;
    logic              misalign_q, misalign_d;

    logic              ret_hit, ret_miss;
    logic              ras_push, ras_pop;
    logic [ADDR_W-1:0] ras_target;
    logic              redirect;
    logic [ADDR_W-1:0] target;

`ifdef PC_SEQ_RAS_EN
    logic              ras_empty_w, ras_full_w;
    logic [ADDR_W-1:0] ras_data_w;

    pc_ras #(
        .ADDR_W (ADDR_W),
        .DEPTH  (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .rst       (rst),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_q + INC_VAL),
        .pop_data  (ras_data_w),
        .empty     (ras_empty_w),
        .full      (ras_full_w)
    );

    assign ret_hit    = ret_valid && !ras_empty_w;
    assign ret_miss   = ret_valid && ras_empty_w;
    assign ras_target = ras_data_w;
    assign ras_empty  = ras_empty_w;

    logic unused_ras;
    assign unused_ras = ras_full_w;
`else
    // Without a stack a call is just a jump and returns are dropped.
    assign ret_hit    = 1'b0;
    assign ret_miss   = 1'b0;
    assign ras_target = '0;
    assign ras_empty  = 1'b1;

    localparam int unsigned UNUSED_RAS_DEPTH = RAS_DEPTH;
    logic unused_ras;
    assign unused_ras = ^{ret_valid, ras_push, ras_pop};
`endif

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        flush_d    = 1'b0;
        misalign_d = 1'b0;
        ras_push   = 1'b0;
        ras_pop    = 1'b0;
        redirect   = 1'b0;
        target     = '0;
        unique case (state_q)
            BOOT: state_d = RUN;
            RUN, STALL: begin
                if (halt) begin
                    state_d = HALT;
                end else begin
                    if (ret_hit) begin
                        redirect = 1'b1;
                        target   = ras_target;
                        ras_pop  = 1'b1;
                    end else if (call_valid || jmp_valid) begin
                        redirect = 1'b1;
                        target   = jmp_target;
                        ras_push = call_valid;
                    end else if (br_valid && br_taken) begin
                        redirect = 1'b1;
                        target   = br_target;
                    end
                    // A redirect overrides a simultaneous stall.
                    if (redirect) begin
                        state_d    = RUN;
                        pc_d       = target & ~OFFSET_MASK;
                        flush_d    = 1'b1;
                        misalign_d = |(target & OFFSET_MASK);
                    end else if (stall) begin
                        state_d = STALL;
                    end else begin
                        state_d = RUN;
                        pc_d    = pc_q + INC_VAL;
                    end
                    if (ret_miss) begin
                        misalign_d = 1'b1;
                    end
                end
            end
            HALT: begin
                if (resume && !halt) begin
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= BOOT;
            pc_q       <= RESET_PC;
            flush_q    <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            flush_q    <= flush_d;
            misalign_q <= misalign_d;
        end
    end

    assign pc_out   = pc_q;
    assign pc_valid = (state_q == RUN);
    assign flush    = flush_q;
    assign misalign = misalign_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer; RAS cases run when PC_SEQ_RAS_EN is defined.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall, br_valid, br_taken, jmp_valid, call_valid, ret_valid, halt, resume;
    logic [31:0] br_target, jmp_target;
    logic [31:0] pc_out;
    logic        pc_valid, flush, misalign, ras_empty;

    int tests_run = 0;
    int tests_failed = 0;

    pc_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .stall      (stall),
        .br_valid   (br_valid),
        .br_taken   (br_taken),
        .br_target  (br_target),
        .jmp_valid  (jmp_valid),
        .jmp_target (jmp_target),
        .call_valid (call_valid),
        .ret_valid  (ret_valid),
        .halt       (halt),
        .resume     (resume),
        .pc_out     (pc_out),
        .pc_valid   (pc_valid),
        .flush      (flush),
        .misalign   (misalign),
        .ras_empty  (ras_empty)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all(input string tag, input logic [31:0] e_pc, input logic e_valid,
                             input logic e_flush, input logic e_mis);
        check_eq({tag, ".pc"}, pc_out, e_pc);
        check_eq({tag, ".valid"}, {31'd0, pc_valid}, {31'd0, e_valid});
        check_eq({tag, ".flush"}, {31'd0, flush}, {31'd0, e_flush});
        check_eq({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e_mis});
    endtask

    task automatic do_jmp(input logic [31:0] tgt);
        jmp_valid = 1'b1; jmp_target = tgt;
        step();
        jmp_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; stall = 0; br_valid = 0; br_taken = 0; jmp_valid = 0;
        call_valid = 0; ret_valid = 0; halt = 0; resume = 0;
        br_target = '0; jmp_target = '0;

        // Reset and boot sequence
        step();
        check_all("reset", 32'h0, 1'b0, 1'b0, 1'b0);
        check_eq("reset.ras_empty", {31'd0, ras_empty}, 32'd1);
        rst = 1'b0;
        step(); check_all("boot", 32'h0, 1'b1, 1'b0, 1'b0);
        step(); check_eq("inc1", pc_out, 32'h4);
        step(); check_eq("inc2", pc_out, 32'h8);
        step(); check_eq("inc3", pc_out, 32'hC);

        // Jump
        do_jmp(32'h40);
        check_all("jmp", 32'h40, 1'b1, 1'b1, 1'b0);
        step(); check_all("jmp_next", 32'h44, 1'b1, 1'b0, 1'b0);

        // Taken misaligned branch with stall
        br_valid = 1; br_taken = 1; stall = 1; br_target = 32'h102;
        step();
        br_valid = 0; br_taken = 0; stall = 0;
        check_all("br_stall", 32'h100, 1'b1, 1'b1, 1'b1);
        step(); check_all("br_next", 32'h104, 1'b1, 1'b0, 1'b0);

        // Not-taken branch is an ordinary increment
        br_valid = 1; br_taken = 0; br_target = 32'h200;
        step();
        br_valid = 0;
        check_all("br_nt", 32'h108, 1'b1, 1'b0, 1'b0);

        // Stall hold
        do_jmp(32'h20);
        check_eq("jmp20", pc_out, 32'h20);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            check_all($sformatf("stall%0d", i), 32'h20, 1'b0, 1'b0, 1'b0);
        end
        stall = 0;
        step(); check_all("unstall", 32'h24, 1'b1, 1'b0, 1'b0);

        // Halt beats jump, redirects ignored in halt, halt beats resume
        halt = 1; jmp_valid = 1; jmp_target = 32'h300;
        step();
        halt = 0;
        check_all("halt", 32'h24, 1'b0, 1'b0, 1'b0);
        step();
        jmp_valid = 0;
        check_all("halt_jmp", 32'h24, 1'b0, 1'b0, 1'b0);
        halt = 1; resume = 1;
        step();
        halt = 0;
        check_all("halt_res", 32'h24, 1'b0, 1'b0, 1'b0);
        step();
        resume = 0;
        check_all("resume", 32'h24, 1'b1, 1'b0, 1'b0);
        step(); check_eq("resume_inc", pc_out, 32'h28);

`ifndef PC_SEQ_RAS_EN
        // Without the stack a call is a plain jump
        call_valid = 1; jmp_target = 32'h80;
        step();
        call_valid = 0;
        check_all("call_nojmp", 32'h80, 1'b1, 1'b1, 1'b0);
        check_eq("call.ras_empty", {31'd0, ras_empty}, 32'd1);
        ret_valid = 1;
        step();
        ret_valid = 0;
        check_all("ret_ignored", 32'h84, 1'b1, 1'b0, 1'b0);
`endif

        // Wrap at top of address space
        do_jmp(32'hFFFF_FFFC);
        check_eq("jmp_top", pc_out, 32'hFFFF_FFFC);
        step(); check_all("wrap", 32'h0, 1'b1, 1'b0, 1'b0);

        // Reset overrides a pending redirect
        jmp_valid = 1; jmp_target = 32'h500; rst = 1;
        step();
        jmp_valid = 0; rst = 0;
        check_all("rst_mid", 32'h0, 1'b0, 1'b0, 1'b0);
        step(); check_all("rst_boot", 32'h0, 1'b1, 1'b0, 1'b0);

`ifdef PC_SEQ_RAS_EN
        do_jmp(32'h10);
        call_valid = 1; jmp_target = 32'h80;
        step();
        call_valid = 0;
        check_all("call", 32'h80, 1'b1, 1'b1, 1'b0);
        check_eq("call.ras_empty", {31'd0, ras_empty}, 32'd0);
        step(); check_eq("call_inc1", pc_out, 32'h84);
        step(); check_eq("call_inc2", pc_out, 32'h88);
        ret_valid = 1;
        step();
        check_all("ret", 32'h14, 1'b1, 1'b1, 1'b0);
        check_eq("ret.ras_empty", {31'd0, ras_empty}, 32'd1);
        step();
        ret_valid = 0;
        check_all("ret_empty", 32'h18, 1'b1, 1'b0, 1'b1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
